// File: rtl/calc_disp_pkg.sv
// Shared segment codes and types for the calculator display path.
// Codes are active-low, ordered {g,f,e,d,c,b,a}.
package calc_disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam digit_idx_t IDX_LAST = 2'd3;

  // Frame snapshot of the arithmetic result, taken once per refresh frame.
  typedef struct packed {
    logic [3:0] op4;
    logic [3:0] op3;
    logic [3:0] op2;
    logic [3:0] op1;
    logic       neg;
    logic       error;
    logic       temp_dp;
  } shadow_t;

endpackage

// File: rtl/calc_display_mux_seg7_encode.sv
// BCD to active-low seven-segment encoder; purely combinational.
// Latency: 0 cycles. No flow control; values 10..15 render blank.
module seg7_encode
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_mux.sv
// Four-digit multiplexed seven-segment driver; inputs snapshot once per frame.
// Latency: outputs registered, one cycle after the digit-advance tick.
// No backpressure: inputs are sampled only at frame start and ignored otherwise.
module calc_display_mux
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LZB         = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] op1,
  input  logic [3:0] op2,
  input  logic [3:0] op3,
  input  logic [3:0] op4,
  input  logic       neg,
  input  logic       error,
  input  logic       temp_dp,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  digit_idx_t    idx;
  logic          started;
  shadow_t       shadow;

  logic [3:0]    bcd_sel;
  logic [6:0]    enc_seg;
  logic [3:1]    lead_blank;
  logic          lzb_en;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit 3 sits before digit 0 so the first tick after reset opens a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= IDX_LAST;
      started <= 1'b0;
      shadow  <= '0;
    end else if (tick) begin
      idx     <= idx + 2'd1;
      started <= 1'b1;
      if (idx == IDX_LAST) begin
        shadow <= '{op4: op4, op3: op3, op2: op2, op1: op1,
                    neg: neg, error: error, temp_dp: temp_dp};
      end
    end
  end

  always_comb begin
    bcd_sel = shadow.op1;
    case (idx)
      2'd0: bcd_sel = shadow.op1;
      2'd1: bcd_sel = shadow.op2;
      2'd2: bcd_sel = shadow.op3;
      2'd3: bcd_sel = shadow.op4;
      default: bcd_sel = shadow.op1;
    endcase
  end

  seg7_encode u_enc (
    .bcd (bcd_sel),
    .seg (enc_seg)
  );

  // A negative sign occupies digit 3, so the zero scan then starts at digit 2.
  always_comb begin
    lzb_en        = LZB && !shadow.temp_dp;
    lead_blank[3] = lzb_en && !shadow.neg && (shadow.op4 == 4'd0);
    lead_blank[2] = lzb_en && (shadow.neg || lead_blank[3]) && (shadow.op3 == 4'd0);
    lead_blank[1] = lead_blank[2] && (shadow.op2 == 4'd0);
  end

  always_comb begin
    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = enc_seg;
    dp_nxt  = !((idx == 2'd2) && shadow.temp_dp && !shadow.error);

    if (shadow.error) begin
      case (idx)
        2'd3:    seg_nxt = SEG_E;
        2'd2:    seg_nxt = SEG_R;
        2'd1:    seg_nxt = SEG_R;
        default: seg_nxt = SEG_BLANK;
      endcase
    end else if (shadow.neg && (idx == 2'd3)) begin
      seg_nxt = SEG_MINUS;
    end else if ((idx != 2'd0) && lead_blank[idx]) begin
      seg_nxt = SEG_BLANK;
    end

    if (!started) begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_calc_display_mux.sv
// Bench for calc_display_mux with REFRESH_DIV=4, LZB=1; vector table drives frames.
module tb_calc_display_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] op1, op2, op3, op4;
  logic       neg, error, temp_dp;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  calc_display_mux #(.REFRESH_DIV(4), .LZB(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op1     (op1),
    .op2     (op2),
    .op3     (op3),
    .op4     (op4),
    .neg     (neg),
    .error   (error),
    .temp_dp (temp_dp),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op4, op3, op2, op1;
    logic       neg, err, tdp;
    logic [6:0] s3, s2, s1, s0;
    logic       dp_on;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam int NVEC = 10;
  localparam logic [6:0] BL = 7'b1111111;

  vec_t vecs[NVEC];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] a4, a3, a2, a1,
                         input logic n, e, t,
                         input logic [6:0] x3, x2, x1, x0, input logic d);
    vecs[i].op4 = a4; vecs[i].op3 = a3; vecs[i].op2 = a2; vecs[i].op1 = a1;
    vecs[i].neg = n;  vecs[i].err = e;  vecs[i].tdp = t;
    vecs[i].s3 = x3;  vecs[i].s2 = x2;  vecs[i].s1 = x1;  vecs[i].s0 = x0;
    vecs[i].dp_on = d;
  endtask

  task automatic drive_vec(input int i);
    op4 = vecs[i].op4; op3 = vecs[i].op3; op2 = vecs[i].op2; op1 = vecs[i].op1;
    neg = vecs[i].neg; error = vecs[i].err; temp_dp = vecs[i].tdp;
  endtask

  // One frame = four slots of four cycles each, digit 0 first.
  task automatic push_vec(input int i);
    exp_t e;
    for (int slot = 0; slot < 4; slot++) begin
      e.an = 4'b1111;
      e.an[slot] = 1'b0;
      case (slot)
        0: e.seg = vecs[i].s0;
        1: e.seg = vecs[i].s1;
        2: e.seg = vecs[i].s2;
        default: e.seg = vecs[i].s3;
      endcase
      e.dp = (slot == 2 && vecs[i].dp_on) ? 1'b0 : 1'b1;
      for (int r = 0; r < 4; r++) sbq.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    int   k;

    //          op4   op3   op2   op1   neg  err  tdp  dig3        dig2        dig1        dig0        dp
    set_vec(0, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0,1'b0,1'b0, BL,         7'b1111001, 7'b0100100, 7'b0110000, 1'b0);
    set_vec(1, 4'd0, 4'd1, 4'd2, 4'd9, 1'b0,1'b0,1'b0, BL,         7'b1111001, 7'b0100100, 7'b0010000, 1'b0);
    set_vec(2, 4'd0, 4'd0, 4'd4, 4'd7, 1'b1,1'b0,1'b0, 7'b0111111, BL,         7'b0011001, 7'b1111000, 1'b0);
    set_vec(3, 4'd5, 4'd6, 4'd7, 4'd8, 1'b1,1'b1,1'b0, 7'b0000110, 7'b0101111, 7'b0101111, BL,         1'b0);
    set_vec(4, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b1);
    set_vec(5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0, BL,         BL,         BL,         7'b1000000, 1'b0);
    set_vec(6, 4'd1, 4'd0, 4'd0, 4'd5, 1'b0,1'b0,1'b0, 7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010, 1'b0);
    set_vec(7, 4'd0, 4'd0, 4'hC, 4'd8, 1'b0,1'b0,1'b0, BL,         BL,         BL,         7'b0000000, 1'b0);
    set_vec(8, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0,1'b1,1'b1, 7'b0000110, 7'b0101111, 7'b0101111, BL,         1'b0);
    set_vec(9, 4'd9, 4'd0, 4'd0, 4'd6, 1'b1,1'b0,1'b1, 7'b0111111, 7'b1000000, 7'b1000000, 7'b0000010, 1'b1);

    rst_n = 1'b0;
    drive_vec(0);
    push_vec(0);
    repeat (3) @(negedge clk);
    check("reset_an", {12'b0, an}, 16'h000F);
    check("reset_seg", {9'b0, seg}, {9'b0, BL});
    check("reset_dp", {15'b0, dp}, 16'h0001);
    rst_n = 1'b1;

    for (int n = 1; n <= 4 + 16 * NVEC; n++) begin
      @(negedge clk);
      if (n <= 4) begin
        check($sformatf("pre_tick_an_c%0d", n), {12'b0, an}, 16'h000F);
      end else if (sbq.size() == 0) begin
        check("scoreboard_empty", 16'h0001, 16'h0000);
      end else begin
        e = sbq.pop_front();
        check($sformatf("an_c%0d", n), {12'b0, an}, {12'b0, e.an});
        check($sformatf("seg_c%0d", n), {9'b0, seg}, {9'b0, e.seg});
        check($sformatf("dp_c%0d", n), {15'b0, dp}, {15'b0, e.dp});
      end
      // Next frame's inputs change inside the digit-1 slot, well away from capture.
      if (n % 16 == 10 && n / 16 < NVEC - 1) begin
        drive_vec(n / 16 + 1);
        push_vec(n / 16 + 1);
      end
    end

    k = 0;
    while (k < 40 && an !== 4'b1011) begin
      @(negedge clk);
      k++;
    end
    check("find_digit2_slot", {12'b0, an}, 16'h000B);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_an", {12'b0, an}, 16'h000F);
    check("midframe_reset_seg", {9'b0, seg}, {9'b0, BL});
    check("midframe_reset_dp", {15'b0, dp}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n <= 4) check($sformatf("restart_blank_an_c%0d", n), {12'b0, an}, 16'h000F);
      else begin
        check("restart_an", {12'b0, an}, 16'h000E);
        check("restart_seg", {9'b0, seg}, {9'b0, vecs[NVEC-1].s0});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
